// File: rtl/pipelined_control_unit_if.sv
// Fetch <-> decode/control bus for pipelined_control_unit.
// master: fetch/datapath side (drives instruction fields and ALU flags).
// slave : control unit (drives handshake ready and per-stage controls).
interface pipelined_control_unit_if #(
  parameter int unsigned OPCODE_W   = 5,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ALU_CODE_W = 4
);
  logic                  InstrValid;
  logic [OPCODE_W-1:0]   Opcode;
  logic [REG_ADDR_W-1:0] RegDest;
  logic [REG_ADDR_W-1:0] RegSrcA;
  logic [REG_ADDR_W-1:0] RegSrcB;
  logic [1:0]            Flags;
  logic                  InstrReady;
  logic                  ExValid;
  logic                  ExMuxSelDirRegB;
  logic                  ExCrtlMuxValA;
  logic                  ExCrtlMuxValB;
  logic [ALU_CODE_W-1:0] ExCodigoALU;
  logic                  MemValid;
  logic                  MemWriteMem;
  logic                  MemMuxDirMem;
  logic                  WbValid;
  logic                  WbWriteReg;
  logic                  WbMuxDirWrite;
  logic                  WbMuxDato;
  logic [1:0]            WbMuxResult;
  logic [REG_ADDR_W-1:0] WbRegDest;
  logic                  MuxDireccionPC;
  logic                  Flush;

  modport master (
    output InstrValid, Opcode, RegDest, RegSrcA, RegSrcB, Flags,
    input  InstrReady, ExValid, ExMuxSelDirRegB, ExCrtlMuxValA, ExCrtlMuxValB,
           ExCodigoALU, MemValid, MemWriteMem, MemMuxDirMem, WbValid, WbWriteReg,
           WbMuxDirWrite, WbMuxDato, WbMuxResult, WbRegDest, MuxDireccionPC, Flush
  );

  modport slave (
    input  InstrValid, Opcode, RegDest, RegSrcA, RegSrcB, Flags,
    output InstrReady, ExValid, ExMuxSelDirRegB, ExCrtlMuxValA, ExCrtlMuxValB,
           ExCodigoALU, MemValid, MemWriteMem, MemMuxDirMem, WbValid, WbWriteReg,
           WbMuxDirWrite, WbMuxDato, WbMuxResult, WbRegDest, MuxDireccionPC, Flush
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined instruction decoder: decodes the fetch opcode stream into a
// control word carried through EX/MEM/WB, with load-use stall, multi-cycle
// MULT stall and taken-branch flush.
// Ports: clk, rst_n (async active-low), bus (slave modport of
// pipelined_control_unit_if: fetch handshake in, stage controls out).
module pipelined_control_unit #(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned ALU_CODE_W  = 4,
  parameter int unsigned MULT_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipelined_control_unit_if.slave  bus
);

  localparam int unsigned CNT_W    = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;
  localparam int unsigned CNT_LOAD = (MULT_CYCLES > 1) ? (MULT_CYCLES - 2) : 0;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alu;
    logic                  sel_dir_reg_b;
    logic                  val_a;
    logic                  val_b;
    logic                  write_mem;
    logic                  mux_dir_mem;
    logic                  write_reg;
    logic                  mux_dir_write;
    logic                  mux_dato;
    logic [1:0]            mux_result;
    logic                  is_load;
    logic                  is_jmp;
    logic                  is_beq;
    logic                  is_bne;
    logic [REG_ADDR_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic                  write_reg;
    logic                  mux_dir_write;
    logic                  mux_dato;
    logic [1:0]            mux_result;
    logic [REG_ADDR_W-1:0] rd;
  } wb_t;

  typedef struct packed {
    logic write_mem;
    logic mux_dir_mem;
    wb_t  wb;
  } mem_t;

  typedef enum logic {S_IDLE, S_MBUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  ex_t              r_ex;
  logic             r_ex_valid;
  mem_t             r_mem;
  logic             r_mem_valid;
  wb_t              r_wb;
  logic             r_wb_valid;

  ex_t  w_dec;
  logic w_dec_reads;
  logic w_dec_mult;
  logic w_alu_op;
  logic w_load_use;
  logic w_taken;
  logic w_ready;
  logic w_xfer;
  mem_t w_ex_to_mem;

  // Opcode decode of the instruction presented by fetch.
  always_comb begin
    w_dec       = '0;
    w_dec_reads = 1'b1;
    w_dec_mult  = 1'b0;
    w_alu_op    = 1'b0;
    w_dec.rd    = bus.RegDest;
    case (bus.Opcode)
      OPCODE_W'(5'b00000), OPCODE_W'(5'b00001): begin
        w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0011); w_dec.val_b = bus.Opcode[0];
      end
      OPCODE_W'(5'b00010), OPCODE_W'(5'b00011): begin
        w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0100); w_dec.val_b = bus.Opcode[0];
      end
      OPCODE_W'(5'b00100), OPCODE_W'(5'b00101): begin
        w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0101); w_dec.val_b = bus.Opcode[0];
      end
      OPCODE_W'(5'b00110): begin w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0000); end
      OPCODE_W'(5'b00111): begin w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0001); end
      OPCODE_W'(5'b01000): begin w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0110); end
      OPCODE_W'(5'b01001): begin w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0010); end
      OPCODE_W'(5'b10000): begin w_alu_op = 1'b1; w_dec.alu = ALU_CODE_W'(4'b0111); end
      OPCODE_W'(5'b01010), OPCODE_W'(5'b01011): begin
        w_dec.mux_result = 2'b11;
        w_dec.write_reg  = 1'b1;
        w_dec.is_load    = 1'b1;
        w_dec.val_a      = bus.Opcode[0];
      end
      OPCODE_W'(5'b01100), OPCODE_W'(5'b01101): begin
        w_dec.sel_dir_reg_b = 1'b1;
        w_dec.write_mem     = 1'b1;
        w_dec.mux_dir_mem   = 1'b1;
        w_dec.val_a         = bus.Opcode[0];
      end
      OPCODE_W'(5'b01110), OPCODE_W'(5'b01111): begin
        w_dec.mux_result = 2'b00;
        w_dec.write_reg  = 1'b1;
        w_dec.mux_dato   = 1'b1;
        w_dec.val_a      = bus.Opcode[0];
        // immediate MOVE has no register source
        w_dec_reads      = ~bus.Opcode[0];
      end
      OPCODE_W'(5'b10011): begin w_dec.is_jmp = 1'b1; w_dec_reads = 1'b0; end
      OPCODE_W'(5'b10100): w_dec.is_bne = 1'b1;
      OPCODE_W'(5'b10101): w_dec.is_beq = 1'b1;
      OPCODE_W'(5'b10110): begin
        w_dec.alu           = ALU_CODE_W'(4'b1000);
        w_dec.mux_result    = 2'b01;
        w_dec.mux_dir_write = 1'b1;
        w_dec.write_reg     = 1'b1;
        w_dec_mult          = 1'b1;
      end
      default: w_dec_reads = 1'b0;
    endcase
    if (w_alu_op) begin
      w_dec.write_reg   = 1'b1;
      w_dec.mux_result  = 2'b10;
      w_dec.mux_dato    = 1'b1;
      w_dec.mux_dir_mem = 1'b1;
    end
  end

  // Hazard, branch resolution and handshake.
  always_comb begin
    w_load_use = r_ex_valid && r_ex.is_load && w_dec_reads &&
                 ((r_ex.rd == bus.RegSrcA) || (r_ex.rd == bus.RegSrcB));
    w_taken    = r_ex_valid && (r_ex.is_jmp ||
                                (r_ex.is_beq && (bus.Flags == 2'b01)) ||
                                (r_ex.is_bne && !bus.Flags[0]));
    // rst_n gating keeps every output low while reset is held
    w_ready    = rst_n && (r_state == S_IDLE) && !w_load_use;
    w_xfer     = bus.InstrValid && w_ready;
    w_ex_to_mem.write_mem        = r_ex.write_mem;
    w_ex_to_mem.mux_dir_mem      = r_ex.mux_dir_mem;
    w_ex_to_mem.wb.write_reg     = r_ex.write_reg;
    w_ex_to_mem.wb.mux_dir_write = r_ex.mux_dir_write;
    w_ex_to_mem.wb.mux_dato      = r_ex.mux_dato;
    w_ex_to_mem.wb.mux_result    = r_ex.mux_result;
    w_ex_to_mem.wb.rd            = r_ex.rd;
  end

  // MULT occupancy FSM: holds EX for MULT_CYCLES cycles in total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((MULT_CYCLES > 1) && w_xfer && w_dec_mult && !w_taken) begin
            r_state <= S_MBUSY;
            r_cnt   <= CNT_W'(CNT_LOAD);
          end
        end
        S_MBUSY: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage registers: EX holds during MULT stall, MEM takes bubbles meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_ex_valid  <= 1'b0;
      r_mem       <= '0;
      r_mem_valid <= 1'b0;
      r_wb        <= '0;
      r_wb_valid  <= 1'b0;
    end else begin
      if (r_state == S_MBUSY) begin
        r_mem       <= '0;
        r_mem_valid <= 1'b0;
      end else begin
        r_mem       <= w_ex_to_mem;
        r_mem_valid <= r_ex_valid;
        r_ex_valid  <= w_xfer && !w_taken;
        r_ex        <= (w_xfer && !w_taken) ? w_dec : '0;
      end
      r_wb       <= r_mem.wb;
      r_wb_valid <= r_mem_valid;
    end
  end

  // Outputs, each gated by its stage valid.
  assign bus.InstrReady      = w_ready;
  assign bus.ExValid         = r_ex_valid;
  assign bus.ExMuxSelDirRegB = r_ex_valid & r_ex.sel_dir_reg_b;
  assign bus.ExCrtlMuxValA   = r_ex_valid & r_ex.val_a;
  assign bus.ExCrtlMuxValB   = r_ex_valid & r_ex.val_b;
  assign bus.ExCodigoALU     = r_ex.alu & {ALU_CODE_W{r_ex_valid}};
  assign bus.MemValid        = r_mem_valid;
  assign bus.MemWriteMem     = r_mem_valid & r_mem.write_mem;
  assign bus.MemMuxDirMem    = r_mem_valid & r_mem.mux_dir_mem;
  assign bus.WbValid         = r_wb_valid;
  assign bus.WbWriteReg      = r_wb_valid & r_wb.write_reg;
  assign bus.WbMuxDirWrite   = r_wb_valid & r_wb.mux_dir_write;
  assign bus.WbMuxDato       = r_wb_valid & r_wb.mux_dato;
  assign bus.WbMuxResult     = r_wb.mux_result & {2{r_wb_valid}};
  assign bus.WbRegDest       = r_wb.rd & {REG_ADDR_W{r_wb_valid}};
  assign bus.MuxDireccionPC  = w_taken;
  assign bus.Flush           = w_taken;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed testbench for pipelined_control_unit (default parameters).
module tb_pipelined_control_unit;

  localparam int unsigned OPCODE_W    = 5;
  localparam int unsigned REG_ADDR_W  = 4;
  localparam int unsigned ALU_CODE_W  = 4;
  localparam int unsigned MULT_CYCLES = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(
    .OPCODE_W(OPCODE_W), .REG_ADDR_W(REG_ADDR_W), .ALU_CODE_W(ALU_CODE_W)
  ) bus ();

  pipelined_control_unit #(
    .OPCODE_W(OPCODE_W), .REG_ADDR_W(REG_ADDR_W),
    .ALU_CODE_W(ALU_CODE_W), .MULT_CYCLES(MULT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction (or idle when v=0) and let combinational outputs settle.
  task automatic present(input logic v, input logic [4:0] op,
                         input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    bus.InstrValid = v;
    bus.Opcode     = OPCODE_W'(op);
    bus.RegDest    = REG_ADDR_W'(rd);
    bus.RegSrcA    = REG_ADDR_W'(ra);
    bus.RegSrcB    = REG_ADDR_W'(rb);
    #1;
  endtask

  task automatic idle();
    present(1'b0, 5'b10001, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.Flags = 2'b00;
    idle();
    // reset state
    check("rst_ready",  32'(bus.InstrReady), 32'd0);
    check("rst_exv",    32'(bus.ExValid), 32'd0);
    check("rst_memv",   32'(bus.MemValid), 32'd0);
    check("rst_wbv",    32'(bus.WbValid), 32'd0);
    check("rst_pc",     32'(bus.MuxDireccionPC), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready",  32'(bus.InstrReady), 32'd1);
    check("rel_exv",    32'(bus.ExValid), 32'd0);
    tick();

    // streaming ADD, ADDI, XOR
    present(1'b1, 5'b00000, 4'd1, 4'd2, 4'd4);
    check("st_ready0", 32'(bus.InstrReady), 32'd1);
    tick();
    present(1'b1, 5'b00001, 4'd5, 4'd2, 4'd4);
    check("st_alu0",  32'(bus.ExCodigoALU), 32'h3);
    check("st_valb0", 32'(bus.ExCrtlMuxValB), 32'd0);
    tick();
    present(1'b1, 5'b01001, 4'd6, 4'd2, 4'd4);
    check("st_alu1",  32'(bus.ExCodigoALU), 32'h3);
    check("st_valb1", 32'(bus.ExCrtlMuxValB), 32'd1);
    check("st_memv",  32'(bus.MemValid), 32'd1);
    check("st_mdm",   32'(bus.MemMuxDirMem), 32'd1);
    tick();
    idle();
    check("st_alu2",  32'(bus.ExCodigoALU), 32'h2);
    check("st_valb2", 32'(bus.ExCrtlMuxValB), 32'd0);
    check("st_wbwr0", 32'(bus.WbWriteReg), 32'd1);
    check("st_wbres0", 32'(bus.WbMuxResult), 32'h2);
    check("st_wbrd0", 32'(bus.WbRegDest), 32'd1);
    check("st_wbdato0", 32'(bus.WbMuxDato), 32'd1);
    tick();
    check("st_wbwr1", 32'(bus.WbWriteReg), 32'd1);
    check("st_wbrd1", 32'(bus.WbRegDest), 32'd5);
    tick();
    check("st_wbres2", 32'(bus.WbMuxResult), 32'h2);
    check("st_wbrd2", 32'(bus.WbRegDest), 32'd6);
    drain();

    // load-use: LOAD r3 then AND reading r3
    present(1'b1, 5'b01010, 4'd3, 4'd1, 4'd2);
    check("lu_ready0", 32'(bus.InstrReady), 32'd1);
    tick();
    present(1'b1, 5'b00110, 4'd7, 4'd3, 4'd8);
    check("lu_stall", 32'(bus.InstrReady), 32'd0);
    check("lu_exv0",  32'(bus.ExValid), 32'd1);
    tick();
    check("lu_bubble", 32'(bus.ExValid), 32'd0);
    check("lu_ready1", 32'(bus.InstrReady), 32'd1);
    check("lu_memv",   32'(bus.MemValid), 32'd1);
    check("lu_mdm",    32'(bus.MemMuxDirMem), 32'd0);
    tick();
    idle();
    check("lu_and_ex",  32'(bus.ExValid), 32'd1);
    check("lu_and_alu", 32'(bus.ExCodigoALU), 32'h0);
    check("lu_wbres",   32'(bus.WbMuxResult), 32'h3);
    check("lu_wbrd",    32'(bus.WbRegDest), 32'd3);
    tick();
    check("lu_nodup", 32'(bus.ExValid), 32'd0);
    tick();
    check("lu_and_wb", 32'(bus.WbRegDest), 32'd7);
    check("lu_memv2",  32'(bus.MemValid), 32'd0);
    drain();

    // MULT followed by ADD
    present(1'b1, 5'b10110, 4'd9, 4'd1, 4'd2);
    check("mu_ready0", 32'(bus.InstrReady), 32'd1);
    tick();
    present(1'b1, 5'b00000, 4'd10, 4'd4, 4'd5);
    check("mu_ready1", 32'(bus.InstrReady), 32'd0);
    check("mu_alu1",   32'(bus.ExCodigoALU), 32'h8);
    tick();
    check("mu_ready2", 32'(bus.InstrReady), 32'd0);
    check("mu_alu2",   32'(bus.ExCodigoALU), 32'h8);
    check("mu_memv2",  32'(bus.MemValid), 32'd0);
    tick();
    check("mu_ready3", 32'(bus.InstrReady), 32'd1);
    check("mu_alu3",   32'(bus.ExCodigoALU), 32'h8);
    check("mu_memv3",  32'(bus.MemValid), 32'd0);
    tick();
    idle();
    check("mu_add_alu", 32'(bus.ExCodigoALU), 32'h3);
    check("mu_memv4",   32'(bus.MemValid), 32'd1);
    tick();
    check("mu_wbres",  32'(bus.WbMuxResult), 32'h1);
    check("mu_wbdw",   32'(bus.WbMuxDirWrite), 32'd1);
    check("mu_wbrd",   32'(bus.WbRegDest), 32'd9);
    check("mu_memv5",  32'(bus.MemValid), 32'd1);
    tick();
    check("mu_add_wb", 32'(bus.WbRegDest), 32'd10);
    check("mu_add_res", 32'(bus.WbMuxResult), 32'h2);
    drain();

    // BEQ taken (Flags=01): following ADD is discarded
    bus.Flags = 2'b01;
    present(1'b1, 5'b10101, 4'd0, 4'd1, 4'd2);
    tick();
    present(1'b1, 5'b00000, 4'd11, 4'd4, 4'd5);
    check("beq_pc",    32'(bus.MuxDireccionPC), 32'd1);
    check("beq_flush", 32'(bus.Flush), 32'd1);
    check("beq_ready", 32'(bus.InstrReady), 32'd1);
    tick();
    idle();
    check("beq_exv",   32'(bus.ExValid), 32'd0);
    check("beq_pc1",   32'(bus.MuxDireccionPC), 32'd0);
    tick();
    check("beq_nomem", 32'(bus.MemValid), 32'd0);
    drain();

    // BEQ not taken (Flags=10)
    present(1'b1, 5'b10101, 4'd0, 4'd1, 4'd2);
    tick();
    bus.Flags = 2'b10;
    present(1'b1, 5'b00000, 4'd12, 4'd4, 4'd5);
    check("beqn_pc",    32'(bus.MuxDireccionPC), 32'd0);
    check("beqn_flush", 32'(bus.Flush), 32'd0);
    tick();
    idle();
    check("beqn_exv", 32'(bus.ExValid), 32'd1);
    drain();

    // BNE taken with Flags=00, not taken with Flags=01
    present(1'b1, 5'b10100, 4'd0, 4'd1, 4'd2);
    tick();
    bus.Flags = 2'b00;
    idle();
    check("bne_pc",    32'(bus.MuxDireccionPC), 32'd1);
    check("bne_flush", 32'(bus.Flush), 32'd1);
    bus.Flags = 2'b01;
    #1;
    check("bne_nt", 32'(bus.MuxDireccionPC), 32'd0);
    bus.Flags = 2'b00;
    drain();

    // STORE (indexed) then immediate MOVE
    present(1'b1, 5'b01101, 4'd1, 4'd2, 4'd3);
    tick();
    present(1'b1, 5'b01111, 4'd4, 4'd0, 4'd0);
    check("sto_selb", 32'(bus.ExMuxSelDirRegB), 32'd1);
    check("sto_vala", 32'(bus.ExCrtlMuxValA), 32'd1);
    tick();
    idle();
    check("sto_wm",   32'(bus.MemWriteMem), 32'd1);
    check("mov_vala", 32'(bus.ExCrtlMuxValA), 32'd1);
    check("mov_selb", 32'(bus.ExMuxSelDirRegB), 32'd0);
    tick();
    check("sto_wbwr", 32'(bus.WbWriteReg), 32'd0);
    tick();
    check("mov_wbres", 32'(bus.WbMuxResult), 32'h0);
    check("mov_wbdato", 32'(bus.WbMuxDato), 32'd1);
    drain();

    // undefined 11111 and reserved 10001 decode as valid NOPs
    present(1'b1, 5'b11111, 4'd5, 4'd1, 4'd2);
    tick();
    present(1'b1, 5'b10001, 4'd6, 4'd1, 4'd2);
    check("nop_exv",  32'(bus.ExValid), 32'd1);
    check("nop_alu",  32'(bus.ExCodigoALU), 32'h0);
    check("nop_selb", 32'(bus.ExMuxSelDirRegB), 32'd0);
    tick();
    idle();
    check("nop_exv2", 32'(bus.ExValid), 32'd1);
    check("nop_memv", 32'(bus.MemValid), 32'd1);
    check("nop_wm",   32'(bus.MemWriteMem), 32'd0);
    tick();
    check("nop_wbv",  32'(bus.WbValid), 32'd1);
    check("nop_wbwr", 32'(bus.WbWriteReg), 32'd0);
    drain();

    // reset asserted mid-MULT
    present(1'b1, 5'b10110, 4'd9, 4'd1, 4'd2);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_exv",   32'(bus.ExValid), 32'd0);
    check("mrst_alu",   32'(bus.ExCodigoALU), 32'h0);
    check("mrst_ready", 32'(bus.InstrReady), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_ready1", 32'(bus.InstrReady), 32'd1);
    tick();
    check("mrst_memv", 32'(bus.MemValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised, pipelined successor to the single-cycle decoder. Accepts an opcode stream from fetch under a valid/ready handshake and decodes it into a control word. The word is carried through EX, MEM and WB stage registers. The block detects load-use hazards, stalls for multi-cycle multiplies and flushes on taken branches, and sits between the fetch unit and the datapath muxes, ALU, data memory and register file.

## Interface
- OPCODE_W, 5, opcode width; encodings above 5'b10111 decode as NOP.
- REG_ADDR_W, 4, register address width.
- ALU_CODE_W, 4, ALU operation code width.
- MULT_CYCLES, 3, EX occupancy of MULT in cycles (≥1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- InstrValid  in  1  fetch presents an instruction.
- Opcode  in  OPCODE_W  opcode of presented instruction.
- RegDest, RegSrcA, RegSrcB  in  REG_ADDR_W each  register fields of presented instruction.
- Flags  in  2  ALU flags; Flags[0]=equal/zero, Flags[1]=greater.
- InstrReady  out  1  decode accepts this cycle.
- ExValid, ExMuxSelDirRegB, ExCrtlMuxValA, ExCrtlMuxValB  out  1 each  EX-stage controls.
- ExCodigoALU  out  ALU_CODE_W  ALU operation.
- MemValid, MemWriteMem, MemMuxDirMem  out  1 each  MEM-stage controls.
- WbValid, WbWriteReg, WbMuxDirWrite, WbMuxDato  out  1 each  WB-stage controls.
- WbMuxResult  out  2  result source select.
- WbRegDest  out  REG_ADDR_W  write-back register.
- MuxDireccionPC  out  1  take branch target.
- Flush  out  1  discard instruction in decode.

## Operation
- Decode table:
  - ALU ops ADD/SUB/CMP/AND/OR/NOT/XOR/SHL use opcodes 00000–01001 and 10000, with ALU codes 0011/0100/0101/0000/0001/0110/0010/0111. Each has WriteReg=1, MuxResult=10, MuxDato=1, MuxDirMem=1.
  - Immediate ADD/SUB/CMP (odd opcodes 00001/00011/00101) set CrtlMuxValB=1.
  - LOAD is 01010/01011: MuxResult=11, WriteReg=1, MuxDirMem=0; 01011 sets CrtlMuxValA=1.
  - STORE is 01100/01101: MuxSelDirRegB=1, WriteMem=1, MuxDirMem=1; 01101 sets CrtlMuxValA=1.
  - MOVE is 01110/01111: MuxResult=00, WriteReg=1, MuxDato=1; 01111 sets CrtlMuxValA=1.
  - JMP is 10011, BNE is 10100, BEQ is 10101.
  - MULT is 10110: ALU 1000, MuxResult=01, MuxDirWrite=1, WriteReg=1.
  - 10001, 10010, 10111 and undefined opcodes decode as NOP: all controls 0.
- Accept and advance:
  - Transfer occurs when InstrValid & InstrReady.
  - An accepted word loads EX at the next edge; otherwise EX loads a bubble (all 0).
  - EX→MEM→WB advance every cycle, except that EX holds during a MULT stall.
- Gating: every Mem*/Wb* write enable and every Ex* control is 0 whenever the stage's valid bit is 0.
- Load-use hazard:
  - Condition: EX holds a LOAD whose RegDest equals the decode RegSrcA or RegSrcB, and the decode op reads registers (not JMP/NOP/immediate MOVE).
  - Response: InstrReady=0 for one cycle and a bubble enters EX.
- MULT state machine:
  - States are IDLE and MBUSY.
  - On MULT entering EX with MULT_CYCLES>1: move to MBUSY, load the counter with MULT_CYCLES-2, hold InstrReady=0 and hold the EX contents.
  - While in MBUSY, bubbles enter MEM.
  - When the counter reaches 0, return to IDLE; MULT advances to MEM on the next edge.
  - MULT_CYCLES=1 gives no stall.
- Branches:
  - Resolved in EX from the current Flags.
  - JMP is always taken; BEQ is taken when Flags==2'b01; BNE is taken when Flags[0]==0.
  - Taken: MuxDireccionPC=1 and Flush=1, combinational, for that one EX cycle. Any decode transfer in that cycle is discarded and a bubble loads EX. InstrReady stays 1.
- Priority: reset > MULT stall > flush > load-use stall. Branches never coexist with a MULT in EX.

## Timing
- Reset:
  - All stage valids and all outputs are 0.
  - InstrReady=1 after rst_n is released.
  - The FSM goes to IDLE and the counter to 0.
  - Assertion mid-MULT or mid-stall aborts immediately and asynchronously.
- Latency: a word accepted at edge N drives Ex* during cycle N..N+1, Mem* one cycle later and Wb* two cycles later. Throughput is 1 per cycle with no hazards.
- InstrReady is combinational from EX contents, decode register fields and FSM state. There is no combinational path from InstrValid to InstrReady.
- Flags are sampled only in cycles when a branch is valid in EX.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 within the same cycle. Release rst_n → InstrReady=1 with valids 0.
- Streaming: ADD (00000), ADDI (00001), XOR (01001) back-to-back → ExCodigoALU 0011, 0011, 0010 on consecutive cycles. ExCrtlMuxValB is 0, 1, 0. WbWriteReg=1 and WbMuxResult=10 three cycles after each accept.
- Load-use: LOAD to r3, then AND reading RegSrcA=r3 → InstrReady=0 for exactly one cycle and one bubble in EX (ExValid=0). AND completes with no duplicate.
- MULT: MULT_CYCLES=3, MULT followed by ADD → InstrReady=0 for 2 cycles and ExCodigoALU=1000 held for 3 cycles. WbMuxResult=01 with WbMuxDirWrite=1. ADD follows the MULT with no loss.
- Branches:
  - BEQ with Flags=01 → MuxDireccionPC=1 and Flush=1 for one cycle; the following instruction never reaches MemValid.
  - BEQ with Flags=10 → no flush.
  - BNE with Flags=00 → taken.
- Undefined opcode 11111 and reserved 10001 → all stage write enables 0, while ExValid=1.
